// File: rtl/exec_ld_xix_disp_pkg.sv
// Shared definitions for the indexed-load/store execution sequencer.
//   state_t            : sequencer states
//   REG_*              : Z80 8-bit register codes (110 is the (HL) slot, illegal here)
//   ADD_CYCLES_DEFAULT : idle cycles between displacement fetch and data access
//   reg_code_legal()   : 1 when a register code names a plain 8-bit register
package exec_ld_xix_disp_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_D = 3'd1,
        S_ADD     = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [2:0] REG_B       = 3'b000;
    localparam logic [2:0] REG_C       = 3'b001;
    localparam logic [2:0] REG_D       = 3'b010;
    localparam logic [2:0] REG_E       = 3'b011;
    localparam logic [2:0] REG_H       = 3'b100;
    localparam logic [2:0] REG_L       = 3'b101;
    localparam logic [2:0] REG_ILLEGAL = 3'b110;
    localparam logic [2:0] REG_A       = 3'b111;

    localparam int unsigned ADD_CYCLES_DEFAULT = 5;

    function automatic logic reg_code_legal(input logic [2:0] code);
        case (code)
            REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A: return 1'b1;
            REG_ILLEGAL:                                     return 1'b0;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_ea_adder.sv
// Effective-address adder for indexed addressing: base + sign-extended
// 8-bit displacement, modulo 2^16.
//   base : 16-bit index register value
//   disp : 8-bit two's-complement displacement
//   ea   : resulting 16-bit address
module exec_ea_adder (
    input  logic [15:0] base,
    input  logic [7:0]  disp,
    output logic [15:0] ea
);

    assign ea = base + {{8{disp[7]}}, disp};

endmodule

// File: rtl/exec_ld_xix_disp.sv
// Execution sequencer for LD r,(IX/IY+d) and LD (IX/IY+d),r.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start from the prefix decoder
// S_FETCH_D | reading the displacement byte at the captured PC
// S_ADD     | ADD_CYCLES idle cycles, EA registered on exit
// S_MEM     | data read (load) or write (store) at EA
// S_WB      | register writeback of the loaded byte
// S_DONE    | one-cycle completion pulse
//
// Ports: CLK/notRESET clock and async active-low reset; start/is_Y/is_store/
// reg_sel/PC/IX/IY/reg_rdata decoded instruction and operands; mem_* bus
// master interface; pc_inc displacement-consumed pulse; reg_we/reg_waddr/
// reg_wdata register writeback; busy/done/err status.
module exec_ld_xix_disp
    import exec_ld_xix_disp_pkg::*;
#(
    parameter int unsigned ADD_CYCLES = ADD_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        notRESET,
    input  logic        start,
    input  logic        is_Y,
    input  logic        is_store,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] PC,
    input  logic [15:0] IX,
    input  logic [15:0] IY,
    input  logic [7:0]  reg_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        pc_inc,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] ADD_CNT = ADD_CYCLES[3:0];

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        store_q;
    logic [2:0]  rsel_q;
    logic [7:0]  sdata_q;
    logic [15:0] base_q;
    logic [15:0] pc_q;
    logic [7:0]  d_q;
    logic [15:0] ea_q;
    logic [7:0]  ld_q;
    logic [7:0]  disp;
    logic [15:0] ea_sum;
    logic        accept;

    assign accept = (state == S_IDLE) && start && reg_code_legal(reg_sel);

    // With no ADD cycles the EA must be formed in the displacement ack
    // cycle, before d_q holds the byte, so feed the bus data straight in.
    assign disp = (state == S_FETCH_D) ? mem_rdata : d_q;

    exec_ea_adder u_ea (
        .base (base_q),
        .disp (disp),
        .ea   (ea_sum)
    );

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            store_q <= 1'b0;
            rsel_q  <= 3'd0;
            sdata_q <= 8'd0;
            base_q  <= 16'd0;
            pc_q    <= 16'd0;
            d_q     <= 8'd0;
            ea_q    <= 16'd0;
            ld_q    <= 8'd0;
            pc_inc  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_inc <= (state == S_FETCH_D) && mem_ack;
            err    <= (state == S_IDLE) && start && !reg_code_legal(reg_sel);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        store_q <= is_store;
                        rsel_q  <= reg_sel;
                        sdata_q <= reg_rdata;
                        base_q  <= is_Y ? IY : IX;
                        pc_q    <= PC;
                    end
                end
                S_FETCH_D: begin
                    if (mem_ack) begin
                        d_q <= mem_rdata;
                        cnt <= ADD_CNT;
                        if (ADD_CNT == 4'd0) ea_q <= ea_sum;
                    end
                end
                S_ADD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) ea_q <= ea_sum;
                end
                S_MEM: begin
                    if (mem_ack && !store_q) ld_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 8'd0;
        reg_we    = 1'b0;
        reg_waddr = 3'd0;
        reg_wdata = 8'd0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_FETCH_D;
            end
            S_FETCH_D: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) state_nxt = (ADD_CNT == 4'd0) ? S_MEM : S_ADD;
            end
            S_ADD: begin
                if (cnt == 4'd1) state_nxt = S_MEM;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = ea_q;
                mem_wdata = store_q ? sdata_q : 8'd0;
                if (mem_ack) state_nxt = store_q ? S_DONE : S_WB;
            end
            S_WB: begin
                reg_we    = 1'b1;
                reg_waddr = rsel_q;
                reg_wdata = ld_q;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_ld_xix_disp.sv
// Directed bench for exec_ld_xix_disp: one instance with ADD_CYCLES=5 on a
// memory model with programmable wait states, one with ADD_CYCLES=0 on a
// zero-wait bus. Register and memory writes are matched against a queue of
// expected writes filled when each instruction is launched.
module tb_exec_ld_xix_disp;

    logic        CLK = 1'b0;
    logic        notRESET;
    always #5 CLK = ~CLK;

    logic        start, start1, is_Y, is_store;
    logic [2:0]  reg_sel;
    logic [15:0] PC, IX, IY;
    logic [7:0]  reg_rdata;

    logic        mem_req, mem_we, mem_ack, pc_inc, reg_we, busy, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, reg_wdata;
    logic [2:0]  reg_waddr;

    logic        z_mem_req, z_mem_we, z_pc_inc, z_reg_we, z_busy, z_done, z_err;
    logic [15:0] z_mem_addr;
    logic [7:0]  z_mem_wdata, z_mem_rdata, z_reg_wdata;
    logic [2:0]  z_reg_waddr;

    logic [7:0]  mem [0:65535];

    exec_ld_xix_disp #(.ADD_CYCLES(5)) dut (
        .CLK(CLK), .notRESET(notRESET), .start(start), .is_Y(is_Y),
        .is_store(is_store), .reg_sel(reg_sel), .PC(PC), .IX(IX), .IY(IY),
        .reg_rdata(reg_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc_inc(pc_inc), .reg_we(reg_we),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .busy(busy),
        .done(done), .err(err)
    );

    exec_ld_xix_disp #(.ADD_CYCLES(0)) dut0 (
        .CLK(CLK), .notRESET(notRESET), .start(start1), .is_Y(is_Y),
        .is_store(is_store), .reg_sel(reg_sel), .PC(PC), .IX(IX), .IY(IY),
        .reg_rdata(reg_rdata), .mem_req(z_mem_req), .mem_we(z_mem_we),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .mem_ack(z_mem_req), .pc_inc(z_pc_inc),
        .reg_we(z_reg_we), .reg_waddr(z_reg_waddr), .reg_wdata(z_reg_wdata),
        .busy(z_busy), .done(z_done), .err(z_err)
    );

    assign z_mem_rdata = mem[z_mem_addr];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_mem;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus responder for the ADD_CYCLES=5 instance.
    int          acc_idx = 0;
    int          w_fetch = 0;
    int          w_mem = 0;
    int          waited = 0;
    bit          in_req = 0;
    logic [15:0] held_addr;
    logic        held_we;
    logic [7:0]  held_wdata;
    int          done_cnt = 0, pcinc_cnt = 0, req_cnt = 0, we_cnt = 0, err_cnt = 0;

    always @(negedge CLK) begin
        exp_t e;
        int   w;
        mem_ack = 1'b0;
        if (mem_req) begin
            req_cnt++;
            if (in_req) begin
                check("addr_stable", mem_addr, held_addr);
                check("we_stable", mem_we, held_we);
                check("wdata_stable", mem_wdata, held_wdata);
            end else begin
                in_req     = 1;
                waited     = 0;
                held_addr  = mem_addr;
                held_we    = mem_we;
                held_wdata = mem_wdata;
            end
            w = (acc_idx == 0) ? w_fetch : w_mem;
            if (waited >= w) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                acc_idx++;
                in_req    = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    check("mem_write_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("mw_kind", e.is_mem, 1);
                        check("mw_addr", mem_addr, e.addr);
                        check("mw_data", mem_wdata, e.data);
                    end
                end
            end else begin
                waited++;
            end
        end else begin
            in_req = 0;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (done)   done_cnt++;
        if (pc_inc) pcinc_cnt++;
        if (err)    err_cnt++;
        if (reg_we || z_reg_we) begin
            if (reg_we) we_cnt++;
            check("reg_write_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_kind", e.is_mem, 0);
                check("wb_addr", reg_we ? reg_waddr : z_reg_waddr, e.addr[2:0]);
                check("wb_data", reg_we ? reg_wdata : z_reg_wdata, e.data);
            end
        end
    end

    task automatic set_ops(input logic y, input logic st, input logic [2:0] rs,
                           input logic [15:0] pc, input logic [15:0] ix,
                           input logic [15:0] iy, input logic [7:0] rd);
        is_Y = y; is_store = st; reg_sel = rs; PC = pc; IX = ix; IY = iy; reg_rdata = rd;
    endtask

    // Pulses start for one cycle; returns at the negedge of cycle 1.
    task automatic launch();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 80) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    initial begin
        int cyc, d0, p0, r0, w0, e0;
        start = 0; start1 = 0; mem_ack = 0; mem_rdata = 8'h00;
        set_ops(0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00);
        notRESET = 0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_outputs", {mem_we, mem_addr, mem_wdata, pc_inc, reg_we, reg_waddr, reg_wdata, done, err}, 0);
        repeat (2) @(negedge CLK);
        notRESET = 1;
        @(negedge CLK);

        // Load from IX with negative displacement.
        mem[16'h0100] = 8'hFE; mem[16'h0FFE] = 8'h5A;
        w_fetch = 0; w_mem = 0; acc_idx = 0;
        p0 = pcinc_cnt; w0 = we_cnt;
        sb.push_back('{0, 16'h0007, 8'h5A});
        set_ops(0, 0, 3'b111, 16'h0100, 16'h1000, 16'h5555, 8'h00);
        launch();
        check("t1_busy_rise", busy, 1);
        wait_done(1, cyc);
        check("t1_done_cycle", cyc, 9);
        @(negedge CLK);
        check("t1_busy_fall", busy, 0);
        check("t1_pc_inc", pcinc_cnt - p0, 1);
        check("t1_reg_we", we_cnt - w0, 1);

        // Store through IY with address wrap.
        mem[16'h0200] = 8'h20;
        acc_idx = 0; w0 = we_cnt;
        sb.push_back('{1, 16'h0010, 8'hC3});
        set_ops(1, 1, 3'b000, 16'h0200, 16'h1111, 16'hFFF0, 8'hC3);
        launch();
        wait_done(1, cyc);
        check("t2_done_cycle", cyc, 8);
        @(negedge CLK);
        check("t2_mem", mem[16'h0010], 8'hC3);
        check("t2_no_reg_we", we_cnt - w0, 0);

        // Illegal register code.
        r0 = req_cnt; e0 = err_cnt;
        set_ops(0, 0, 3'b110, 16'h0300, 16'h1000, 16'h2000, 8'h00);
        launch();
        check("t3_err", err, 1);
        check("t3_busy", busy, 0);
        @(negedge CLK);
        check("t3_err_pulse", err, 0);
        repeat (4) @(negedge CLK);
        check("t3_no_req", req_cnt - r0, 0);
        check("t3_err_cnt", err_cnt - e0, 1);
        check("t3_busy_idle", busy, 0);

        // Wait states; operands changed mid-instruction.
        mem[16'h0400] = 8'h7F; mem[16'h207F] = 8'h11;
        acc_idx = 0; w_fetch = 2; w_mem = 3;
        sb.push_back('{0, 16'h0003, 8'h11});
        set_ops(1, 0, 3'b011, 16'h0400, 16'h0000, 16'h2000, 8'h00);
        launch();
        set_ops(0, 1, 3'b001, 16'hBEEF, 16'h9999, 16'h8888, 8'hAA);
        wait_done(1, cyc);
        check("t4_done_cycle", cyc, 14);
        @(negedge CLK);
        w_fetch = 0; w_mem = 0;

        // Reset during ADD, then a start while busy.
        mem[16'h0500] = 8'h05; mem[16'h3005] = 8'h77;
        acc_idx = 0;
        sb.push_back('{0, 16'h0001, 8'h77});
        set_ops(0, 0, 3'b001, 16'h0500, 16'h3000, 16'h0000, 8'h00);
        launch();
        repeat (2) @(negedge CLK);
        notRESET = 0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_outputs", {mem_req, mem_we, mem_addr, reg_we, reg_wdata, done, pc_inc, err}, 0);
        sb.delete();
        w0 = we_cnt;
        repeat (3) @(negedge CLK);
        check("t5_no_wb", we_cnt - w0, 0);
        notRESET = 1;
        @(negedge CLK);
        mem[16'h0600] = 8'h10; mem[16'h4010] = 8'h99;
        acc_idx = 0; d0 = done_cnt; w0 = we_cnt;
        sb.push_back('{0, 16'h0005, 8'h99});
        set_ops(0, 0, 3'b101, 16'h0600, 16'h4000, 16'h0000, 8'h00);
        launch();
        @(negedge CLK);
        set_ops(1, 1, 3'b010, 16'h0700, 16'h0100, 16'h0200, 8'h66);
        launch();
        wait_done(3, cyc);
        check("t5_done_cycle", cyc, 9);
        repeat (12) @(negedge CLK);
        check("t5_done_cnt", done_cnt - d0, 1);
        check("t5_we_cnt", we_cnt - w0, 1);
        check("t5_idle", busy, 0);

        // ADD_CYCLES=0 instance.
        mem[16'h0800] = 8'h80; mem[16'h11B4] = 8'hE7;
        sb.push_back('{0, 16'h0004, 8'hE7});
        set_ops(0, 0, 3'b100, 16'h0800, 16'h1234, 16'h0000, 8'h00);
        start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        cyc = 1;
        while (z_done !== 1'b1 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        check("t6_done_cycle", cyc, 4);
        @(negedge CLK);
        check("t6_busy_fall", z_busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_ld_xix_disp.md
# exec_ld_xix_disp

Execution sequencer for the indexed 8-bit loads and stores LD r,(IX+d), LD r,(IY+d), LD (IX+d),r and LD (IY+d),r. It sits downstream of the DD/FD-prefix opcode decoder and consumes the decoded instruction (direction, index select, register code). It then runs the bus sequence:

- fetch the displacement byte,
- compute the effective address,
- perform the data read or write,
- write back the destination register on loads.

It signals completion to the main control so the next opcode fetch can start.

## Interface
Parameters:
- ADD_CYCLES, default 5: internal idle cycles between displacement fetch and data access, matching Z80 T-state timing. The range 0..15 is legal.

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge.
- notRESET  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse from the decoder that launches an instruction.
- is_Y  in  1  index select: 0 selects IX, 1 selects IY.
- is_store  in  1  0 for LD r,(I?+d); 1 for LD (I?+d),r.
- reg_sel  in  3  Z80 register code: 000 B, 001 C, 010 D, 011 E, 100 H, 101 L, 111 A. Code 110 is illegal.
- PC  in  16  current program counter, pointing at the displacement byte.
- IX, IY  in  16  index registers.
- reg_rdata  in  8  value of the register named by reg_sel; used for stores.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  16  bus address.
- mem_wdata  out  8  bus write data.
- mem_rdata  in  8  bus read data, valid in the ack cycle.
- mem_ack  in  1  bus acknowledge; completes the access on the edge where mem_req=1 and mem_ack=1.
- pc_inc  out  1  one-cycle pulse that increments PC past the displacement.
- reg_we  out  1  register write strobe.
- reg_waddr  out  3  register code to write.
- reg_wdata  out  8  register write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start arrives with an illegal reg_sel.

## Operation
- States: IDLE, FETCH_D, ADD, MEM, WB, DONE.
- IDLE, start=1, reg_sel≠110:
  - capture is_Y, is_store, reg_sel and reg_rdata;
  - capture the base address, IX or IY;
  - go to FETCH_D.
- IDLE, start=1, reg_sel=110: pulse err the next cycle, perform no bus activity, stay in IDLE.
- FETCH_D:
  - drive mem_req=1, mem_we=0, mem_addr=PC;
  - on ack, latch d=mem_rdata and pulse pc_inc;
  - go to ADD, or to MEM directly if ADD_CYCLES=0.
- ADD:
  - a 4-bit counter holds the state for ADD_CYCLES cycles;
  - EA = base + sign-extended d, taken modulo 2^16 (wraps in both directions);
  - EA is registered at ADD exit.
- MEM:
  - drive mem_req=1, mem_addr=EA, mem_we=is_store;
  - on stores, drive mem_wdata with the captured register value;
  - on ack: loads latch mem_rdata and go to WB; stores go to DONE.
- WB: reg_we=1 for one cycle with reg_waddr=the captured reg_sel and reg_wdata=the latched data; then go to DONE.
- DONE: done=1 for one cycle; then go to IDLE.
- start while busy=1 is ignored; captured operands are not disturbed.
- Only captured values are used after start. Changes on PC, IX, IY or reg_rdata mid-instruction have no effect on the sequence.
- Stores of H or L use the captured value, even when the captured base is the address source.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, all capture registers 0.
- Reset assertion mid-instruction aborts immediately. A pending reg_we or mem_req is dropped with no partial writeback.
- mem_req stays high from the first cycle of FETCH_D or MEM through the ack cycle inclusive. mem_addr, mem_we and mem_wdata are stable for that whole interval. mem_req drops the cycle after ack.
- Each wait cycle (mem_req=1, mem_ack=0) adds one cycle of latency.
- With zero-wait acks, measured from the start edge to the done pulse:
  - loads: ADD_CYCLES+4 cycles;
  - stores: ADD_CYCLES+3 cycles.
- busy rises the cycle after start and falls the cycle after done.
- A start coinciding with done is ignored; a new start is accepted only in IDLE.

## Structure
- The shared package holds:
  - the state enumeration;
  - the register-code constants (REG_B..REG_A, REG_ILLEGAL=3'b110);
  - the ADD_CYCLES default.
- One sub-module, exec_ea_adder: a combinational 16-bit base plus sign-extended 8-bit displacement adder, also reusable by indexed arithmetic, logic and bit-operation executors.

## Test plan
- Load from IX with a negative displacement: IX=0x1000, d=0xFE, reg_sel=111, memory[0x0FFE]=0x5A, zero-wait bus. Expect reg_we with waddr=111 and wdata=0x5A, done at cycle 9, one pc_inc pulse.
- Store through IY with address wrap: IY=0xFFF0, d=0x20, reg_sel=000, reg_rdata=0xC3. Expect a write to 0x0010 with data 0xC3, no reg_we, done at cycle 8.
- Illegal register code: start with reg_sel=110. Expect an err pulse, no mem_req, busy stays 0.
- Bus wait states: the ack for FETCH_D is delayed 2 cycles and the ack for MEM is delayed 3 cycles. Expect mem_addr stable throughout each request and done 5 cycles later than the zero-wait case.
- Reset and re-start: notRESET deasserted during ADD, then a second start arrives while busy. Expect all outputs 0 immediately with no reg_we. After reset, the first start runs normally and the start issued while busy had no effect.
- ADD_CYCLES=0 load: expect FETCH_D to go straight to MEM and done at cycle 4.
